// File: rtl/rf_access_arbiter_if.sv
// rf_access_arbiter_if: bundles both requester handshakes and the register-file
// port signals seen by rf_access_arbiter.
//   slave  : arbiter view (takes requests and RF read data, drives acks, read data, RF controls)
//   master : environment view (requesters plus the register file itself)
// With RF_ARB_GRANT_COUNT_EN defined the bundle also carries the per-requester
// grant counters a_grants / b_grants.
interface rf_access_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  // Requester A (processor datapath)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_reg1;
  logic [ADDR_W-1:0] a_reg2;
  logic [ADDR_W-1:0] a_regw;
  logic [DATA_W-1:0] a_dataw;
  logic              a_ack;
  logic [DATA_W-1:0] a_data1;
  logic [DATA_W-1:0] a_data2;

  // Requester B (debug/DMA port)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_reg1;
  logic [ADDR_W-1:0] b_reg2;
  logic [ADDR_W-1:0] b_regw;
  logic [DATA_W-1:0] b_dataw;
  logic              b_ack;
  logic [DATA_W-1:0] b_data1;
  logic [DATA_W-1:0] b_data2;

  // Register file ports
  logic [ADDR_W-1:0] rf_reg1;
  logic [ADDR_W-1:0] rf_reg2;
  logic [ADDR_W-1:0] rf_regw;
  logic [DATA_W-1:0] rf_dataw;
  logic              rf_write;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;

`ifdef RF_ARB_GRANT_COUNT_EN
  logic [7:0]        a_grants;
  logic [7:0]        b_grants;
`endif

  modport slave (
    input  a_req, a_we, a_reg1, a_reg2, a_regw, a_dataw,
    output a_ack, a_data1, a_data2,
    input  b_req, b_we, b_reg1, b_reg2, b_regw, b_dataw,
    output b_ack, b_data1, b_data2,
    output rf_reg1, rf_reg2, rf_regw, rf_dataw, rf_write,
    input  rf_data1, rf_data2
`ifdef RF_ARB_GRANT_COUNT_EN
    , output a_grants, b_grants
`endif
  );

  modport master (
    output a_req, a_we, a_reg1, a_reg2, a_regw, a_dataw,
    input  a_ack, a_data1, a_data2,
    output b_req, b_we, b_reg1, b_reg2, b_regw, b_dataw,
    input  b_ack, b_data1, b_data2,
    input  rf_reg1, rf_reg2, rf_regw, rf_dataw, rf_write,
    output rf_data1, rf_data2
`ifdef RF_ARB_GRANT_COUNT_EN
    , input a_grants, b_grants
`endif
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares one 4x8 register file (two async read ports, one
// write port) between requester A (datapath) and requester B (debug/DMA).
// Each transaction runs IDLE -> SERVE -> ACK: fields are latched at grant, the
// RF is driven for one SERVE cycle (write committed / read data captured at its
// end), and the winner sees a one-cycle ack.
// FIXED_PRIO = 0 : round-robin on contention; 1 : A always wins.
// Optional macro RF_ARB_GRANT_COUNT_EN adds saturating 8-bit grant counters.
module rf_access_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clock,
  input  logic                reset,
  rf_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam bit FIXED_EN = (FIXED_PRIO != 32'sd0);

  state_t            state_r;
  state_t            state_nxt_s;

  logic              grant_any_s;  // a grant is issued this cycle
  logic              grant_b_s;    // the grant goes to B
  logic              owner_b_r;    // requester currently being served is B
  logic              we_r;         // latched transaction type
  logic              last_b_r;     // round-robin pointer: B was served last

  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_reg1_s;
  logic [ADDR_W-1:0] sel_reg2_s;
  logic [ADDR_W-1:0] sel_regw_s;
  logic [DATA_W-1:0] sel_dataw_s;

  // Arbitration: decide whether and to whom a grant is issued in IDLE
  always_comb begin
    grant_any_s = 1'b0;
    grant_b_s   = 1'b0;
    if (state_r == IDLE) begin
      if (bus.a_req && bus.b_req) begin
        grant_any_s = 1'b1;
        if (FIXED_EN) begin
          grant_b_s = 1'b0;
        end else begin
          grant_b_s = ~last_b_r;
        end
      end else if (bus.a_req) begin
        grant_any_s = 1'b1;
        grant_b_s   = 1'b0;
      end else if (bus.b_req) begin
        grant_any_s = 1'b1;
        grant_b_s   = 1'b1;
      end else begin
        grant_any_s = 1'b0;
        grant_b_s   = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_b_s   = 1'b0;
    end
  end

  // Transaction field mux: pick the fields of the requester being granted
  always_comb begin
    sel_we_s    = bus.a_we;
    sel_reg1_s  = bus.a_reg1;
    sel_reg2_s  = bus.a_reg2;
    sel_regw_s  = bus.a_regw;
    sel_dataw_s = bus.a_dataw;
    if (grant_b_s) begin
      sel_we_s    = bus.b_we;
      sel_reg1_s  = bus.b_reg1;
      sel_reg2_s  = bus.b_reg2;
      sel_regw_s  = bus.b_regw;
      sel_dataw_s = bus.b_dataw;
    end else begin
      sel_we_s    = bus.a_we;
      sel_reg1_s  = bus.a_reg1;
      sel_reg2_s  = bus.a_reg2;
      sel_regw_s  = bus.a_regw;
      sel_dataw_s = bus.a_dataw;
    end
  end

  // Next-state logic: one SERVE and one ACK cycle per granted transaction
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = SERVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SERVE:   state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: latch fields at grant, drive RF, capture read data, pulse ack
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_b_r    <= 1'b0;
      we_r         <= 1'b0;
      last_b_r     <= 1'b1;
      bus.rf_reg1  <= {ADDR_W{1'b0}};
      bus.rf_reg2  <= {ADDR_W{1'b0}};
      bus.rf_regw  <= {ADDR_W{1'b0}};
      bus.rf_dataw <= {DATA_W{1'b0}};
      bus.rf_write <= 1'b0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.a_data1  <= {DATA_W{1'b0}};
      bus.a_data2  <= {DATA_W{1'b0}};
      bus.b_data1  <= {DATA_W{1'b0}};
      bus.b_data2  <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          bus.a_ack <= 1'b0;
          bus.b_ack <= 1'b0;
          if (grant_any_s) begin
            owner_b_r    <= grant_b_s;
            last_b_r     <= grant_b_s;
            we_r         <= sel_we_s;
            bus.rf_reg1  <= sel_reg1_s;
            bus.rf_reg2  <= sel_reg2_s;
            bus.rf_regw  <= sel_regw_s;
            bus.rf_dataw <= sel_dataw_s;
            bus.rf_write <= sel_we_s;
          end else begin
            bus.rf_write <= 1'b0;
          end
        end
        SERVE: begin
          bus.rf_write <= 1'b0;
          if (owner_b_r) begin
            bus.b_ack <= 1'b1;
            if (!we_r) begin
              bus.b_data1 <= bus.rf_data1;
              bus.b_data2 <= bus.rf_data2;
            end
          end else begin
            bus.a_ack <= 1'b1;
            if (!we_r) begin
              bus.a_data1 <= bus.rf_data1;
              bus.a_data2 <= bus.rf_data2;
            end
          end
        end
        ACK: begin
          bus.rf_write <= 1'b0;
          bus.a_ack    <= 1'b0;
          bus.b_ack    <= 1'b0;
        end
        default: begin
          bus.rf_write <= 1'b0;
          bus.a_ack    <= 1'b0;
          bus.b_ack    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_ARB_GRANT_COUNT_EN
  // Grant counters: count acks per requester, saturating at 255
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.a_grants <= 8'd0;
      bus.b_grants <= 8'd0;
    end else if (state_r == SERVE) begin
      if (owner_b_r) begin
        if (bus.b_grants != 8'd255) begin
          bus.b_grants <= bus.b_grants + 8'd1;
        end
      end else begin
        if (bus.a_grants != 8'd255) begin
          bus.a_grants <= bus.a_grants + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb_rf_access_arbiter: directed bench for rf_access_arbiter. dut0 is
// round-robin, dut1 fixed-priority; each has its own behavioural 4x8 RF.
module tb_rf_access_arbiter;
  localparam int DW = 8;
  localparam int AW = 2;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  rf_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  rf_access_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  rf_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIXED_PRIO(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));

  // Behavioural register files: async read, write on posedge when rf_write
  logic [7:0] mem0 [4] = '{default: 8'h00};
  logic [7:0] mem1 [4] = '{default: 8'h00};
  assign bus0.rf_data1 = mem0[bus0.rf_reg1];
  assign bus0.rf_data2 = mem0[bus0.rf_reg2];
  assign bus1.rf_data1 = mem1[bus1.rf_reg1];
  assign bus1.rf_data2 = mem1[bus1.rf_reg2];
  always @(posedge clock) if (bus0.rf_write) mem0[bus0.rf_regw] <= bus0.rf_dataw;
  always @(posedge clock) if (bus1.rf_write) mem1[bus1.rf_regw] <= bus1.rf_dataw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One transaction on dut0, bounded; reports ack cycle, write pulses, read data
  task automatic run_txn(input bit is_b, input bit we, input logic [1:0] r1, input logic [1:0] r2,
                         input logic [1:0] rw, input logic [7:0] dw,
                         output int ack_cyc, output int nwr, output logic [7:0] d1, output logic [7:0] d2);
    @(negedge clock);
    if (is_b) begin
      bus0.b_we = we; bus0.b_reg1 = r1; bus0.b_reg2 = r2; bus0.b_regw = rw; bus0.b_dataw = dw;
      bus0.b_req = 1'b1;
    end else begin
      bus0.a_we = we; bus0.a_reg1 = r1; bus0.a_reg2 = r2; bus0.a_regw = rw; bus0.a_dataw = dw;
      bus0.a_req = 1'b1;
    end
    ack_cyc = 0; nwr = 0; d1 = 8'h00; d2 = 8'h00;
    for (int c = 1; c <= 8 && ack_cyc == 0; c++) begin
      @(negedge clock);
      if (bus0.rf_write) begin
        nwr++;
        chk("wr_regw", 32'(bus0.rf_regw), 32'(rw));
        chk("wr_dataw", 32'(bus0.rf_dataw), 32'(dw));
      end
      chk("loser_ack", 32'(is_b ? bus0.a_ack : bus0.b_ack), 32'd0);
      if (is_b ? bus0.b_ack : bus0.a_ack) begin
        ack_cyc = c;
        d1 = is_b ? bus0.b_data1 : bus0.a_data1;
        d2 = is_b ? bus0.b_data2 : bus0.a_data2;
      end
    end
    bus0.a_req = 1'b0;
    bus0.b_req = 1'b0;
    @(negedge clock);
    chk("ack_one_cycle", 32'(is_b ? bus0.b_ack : bus0.a_ack), 32'd0);
    chk("write_dropped", 32'(bus0.rf_write), 32'd0);
  endtask

  typedef struct {
    bit         is_b;
    bit         we;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] rw;
    logic [7:0] dw;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         ack_cyc;
    int         nwr;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] cur_a1, cur_a2, cur_b1, cur_b2;
    int         n0, n1, dbl0;
    bit         who0 [8];
    int         cyc0 [8];
    bit         who1 [6];
    bit         dropped;

    vecs[0] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 8'h5A, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 8'h00, 8'h5A, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 2'd0, 2'd0, 2'd3, 8'h33, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 2'd3, 2'd2, 2'd0, 8'h00, 8'h33, 8'h5A};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 2'd3, 2'd0, 8'h00, 8'h5A, 8'h33};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 8'hC7, 8'h5A, 8'h33};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 8'h81, 8'h33, 8'h5A};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 8'h00, 8'hC7, 8'h81};
    vecs[8] = '{1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 8'h00, 8'h81, 8'h81};

    reset = 1'b0;
    bus0.a_req = 1'b0; bus0.a_we = 1'b0; bus0.a_reg1 = 2'd0; bus0.a_reg2 = 2'd0; bus0.a_regw = 2'd0; bus0.a_dataw = 8'h00;
    bus0.b_req = 1'b0; bus0.b_we = 1'b0; bus0.b_reg1 = 2'd0; bus0.b_reg2 = 2'd0; bus0.b_regw = 2'd0; bus0.b_dataw = 8'h00;
    bus1.a_req = 1'b0; bus1.a_we = 1'b0; bus1.a_reg1 = 2'd0; bus1.a_reg2 = 2'd0; bus1.a_regw = 2'd0; bus1.a_dataw = 8'h00;
    bus1.b_req = 1'b0; bus1.b_we = 1'b0; bus1.b_reg1 = 2'd0; bus1.b_reg2 = 2'd0; bus1.b_regw = 2'd0; bus1.b_dataw = 8'h00;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_acks", 32'({bus0.a_ack, bus0.b_ack, bus1.a_ack, bus1.b_ack}), 32'd0);
    chk("rst_write", 32'({bus0.rf_write, bus1.rf_write}), 32'd0);
    chk("rst_rf_idx", 32'({bus0.rf_reg1, bus0.rf_reg2, bus0.rf_regw}), 32'd0);
    chk("rst_rf_dataw", 32'(bus0.rf_dataw), 32'd0);
    chk("rst_data", 32'({bus0.a_data1, bus0.a_data2, bus0.b_data1, bus0.b_data2}), 32'd0);
    reset = 1'b1;

    // Table-driven single transactions on dut0
    cur_a1 = 8'h00; cur_a2 = 8'h00; cur_b1 = 8'h00; cur_b2 = 8'h00;
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].is_b, vecs[i].we, vecs[i].r1, vecs[i].r2, vecs[i].rw, vecs[i].dw, ack_cyc, nwr, d1, d2);
      chk($sformatf("v%0d_ack_latency", i), 32'(ack_cyc), 32'd2);
      chk($sformatf("v%0d_write_pulses", i), 32'(nwr), vecs[i].we ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_data1", i), 32'(d1), 32'(vecs[i].e1));
      chk($sformatf("v%0d_data2", i), 32'(d2), 32'(vecs[i].e2));
      if (vecs[i].is_b) begin
        cur_b1 = vecs[i].e1; cur_b2 = vecs[i].e2;
      end else begin
        cur_a1 = vecs[i].e1; cur_a2 = vecs[i].e2;
      end
      chk($sformatf("v%0d_a_data_hold", i), 32'({bus0.a_data1, bus0.a_data2}), 32'({cur_a1, cur_a2}));
      chk($sformatf("v%0d_b_data_hold", i), 32'({bus0.b_data1, bus0.b_data2}), 32'({cur_b1, cur_b2}));
    end

    // B write r3=FF with reset asserted during SERVE
    @(negedge clock);
    bus0.b_we = 1'b1; bus0.b_regw = 2'd3; bus0.b_dataw = 8'hFF; bus0.b_req = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_serve_write", 32'(bus0.rf_write), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_write_drop", 32'(bus0.rf_write), 32'd0);
    bus0.b_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("mid_no_ack", 32'(bus0.b_ack), 32'd0);
    end
    chk("mid_r3_kept", 32'(mem0[3]), 32'h33);
    reset = 1'b1;
    run_txn(1'b0, 1'b0, 2'd3, 2'd3, 2'd0, 8'h00, ack_cyc, nwr, d1, d2);
    chk("post_rst_latency", 32'(ack_cyc), 32'd2);
    chk("post_rst_data", 32'({d1, d2}), 32'h3333);
    chk("post_rst_b_data", 32'({bus0.b_data1, bus0.b_data2}), 32'd0);

    // Continuous contention on both DUTs
    reset_pulse();
    @(negedge clock);
    bus0.a_we = 1'b0; bus0.b_we = 1'b0; bus1.a_we = 1'b0; bus1.b_we = 1'b0;
    bus0.a_req = 1'b1; bus0.b_req = 1'b1; bus1.a_req = 1'b1; bus1.b_req = 1'b1;
    n0 = 0; n1 = 0; dbl0 = 0; dropped = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (bus0.a_ack && bus0.b_ack) dbl0++;
      if ((bus0.a_ack || bus0.b_ack) && n0 < 8) begin
        who0[n0] = bus0.b_ack; cyc0[n0] = c; n0++;
      end
      if ((bus1.a_ack || bus1.b_ack) && n1 < 6) begin
        who1[n1] = bus1.b_ack; n1++;
      end
      if (!dropped && n1 == 4) begin
        bus1.a_req = 1'b0; dropped = 1'b1;
      end
    end
    bus0.a_req = 1'b0; bus0.b_req = 1'b0; bus1.b_req = 1'b0;
    chk("rr_ack_count", 32'(n0), 32'd8);
    chk("rr_double_grant", 32'(dbl0), 32'd0);
    for (int i = 0; i < n0 && i < 8; i++) begin
      chk($sformatf("rr_winner%0d", i), 32'(who0[i]), 32'(i % 2));
      if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(cyc0[i] - cyc0[i-1]), 32'd3);
    end
    chk("fp_ack_count", 32'(n1), 32'd6);
    for (int i = 0; i < n1 && i < 6; i++) begin
      chk($sformatf("fp_winner%0d", i), 32'(who1[i]), (i < 4) ? 32'd0 : 32'd1);
    end

`ifdef RF_ARB_GRANT_COUNT_EN
    // Grant counter saturation: 300 A transactions on dut1
    reset_pulse();
    @(negedge clock);
    chk("gc_rst", 32'({bus1.a_grants, bus1.b_grants}), 32'd0);
    bus1.a_req = 1'b1;
    n1 = 0;
    for (int c = 0; c < 1200 && n1 < 300; c++) begin
      @(negedge clock);
      if (bus1.a_ack) begin
        n1++;
        if (n1 == 100) chk("gc_a_100", 32'(bus1.a_grants), 32'd100);
      end
    end
    bus1.a_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("gc_txn_count", 32'(n1), 32'd300);
    chk("gc_a_sat", 32'(bus1.a_grants), 32'd255);
    chk("gc_b_zero", 32'(bus1.b_grants), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares the single 4x8 register file (two async read ports, one write port) between two requesters.
- Requester A is the processor datapath; requester B is the debug/DMA port.
- Each requester issues one read-pair or one write transaction per req/ack handshake.
- The block sequences RF port selects and RFWrite, captures read data, and returns it with a one-cycle ack.

Parameters:
- DATA_W, 8, register data width
- ADDR_W, 2, register index width (4 registers)
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins on contention

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- a_req  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read pair
- a_reg1  in  ADDR_W  A read index 1
- a_reg2  in  ADDR_W  A read index 2
- a_regw  in  ADDR_W  A write index
- a_dataw  in  DATA_W  A write data
- a_ack  out  1  A completion pulse
- a_data1  out  DATA_W  A read data 1
- a_data2  out  DATA_W  A read data 2
- b_req, b_we, b_reg1, b_reg2, b_regw, b_dataw, b_ack, b_data1, b_data2: same as A, for requester B
- rf_reg1  out  ADDR_W  to RF reg1
- rf_reg2  out  ADDR_W  to RF reg2
- rf_regw  out  ADDR_W  to RF regw
- rf_dataw  out  DATA_W  to RF dataw
- rf_write  out  1  to RF RFWrite
- rf_data1  in  DATA_W  from RF data1
- rf_data2  in  DATA_W  from RF data2

Behaviour:
- FSM states: IDLE, SERVE, ACK.
- Reset (reset=0, async):
  - state=IDLE; all outputs 0; rr pointer prefers A.
  - Applies mid-transaction: any pending transaction is abandoned; no ack is issued; an in-flight rf_write drops immediately.
- IDLE:
  - If any req=1, arbitrate, then latch the winner's we/reg1/reg2/regw/dataw into rf_* registers.
  - Record the winner and go to SERVE.
  - Otherwise stay in IDLE.
- Arbitration:
  - FIXED_PRIO=1: A wins whenever a_req=1.
  - FIXED_PRIO=0: on simultaneous requests, the requester not served last wins. A single request always wins. The pointer updates only on grant.
- SERVE (one cycle):
  - rf_reg1/rf_reg2/rf_regw/rf_dataw hold the latched values.
  - rf_write=1 only if the latched we=1; the RF commits at the end of this cycle.
  - For reads, rf_data1/rf_data2 are registered into the winner's data1/data2 at the end of this cycle.
  - Go to ACK.
- ACK (one cycle):
  - Winner's ack=1; rf_write=0; go to IDLE.
- Latency: req sampled at edge N; SERVE during N..N+1; ack high N+1..N+2. Minimum 3 cycles per transaction; back-to-back grants are separated by one IDLE cycle.
- Handshake: requester holds req until it sees ack, then deasserts the following cycle. A req still high in IDLE after ack is a new transaction.
- req dropped before ack: the transaction completes anyway because fields are latched at grant; ack still pulses.
- Write data outputs:
  - For writes, the winner's data1/data2 hold their previous values.
  - The loser's data1/data2/ack are never disturbed.
  - data outputs hold until the next read for that requester.
- Read-after-write from the other requester is ordered by grant order. A read granted after a write returns the new value.

Optional Feature:
- Macro: RF_ARB_GRANT_COUNT_EN.
- Defined:
  - Adds outputs a_grants and b_grants, 8-bit each.
  - Each counter increments once per ack for its requester and saturates at 255.
  - Counters clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then A write r2=0x5A (a_we=1, a_regw=2) -> rf_write=1 for exactly one cycle with rf_regw=2, rf_dataw=0x5A; a_ack pulses 2 cycles after req sampled.
- A read reg1=2, reg2=0 after the above -> a_data1=0x5A, a_data2=0x00 on the a_ack cycle; rf_write stays 0.
- A and B both request every cycle, FIXED_PRIO=0 -> grants alternate A,B,A,B; each ack 3 cycles apart; no double grant.
- Same stimulus, FIXED_PRIO=1 -> A served every transaction; B gets ack only after A drops req.
- B write r3=0xFF, with reset pulled low during SERVE -> no b_ack; rf_write=0 immediately; r3 unchanged if reset precedes the edge; FSM in IDLE after release.
- RF_ARB_GRANT_COUNT_EN defined, 300 A transactions -> a_grants=255 (saturated), b_grants=0.
